// File: rtl/wb_result_arbiter.sv
// wb_result_arbiter: three result queues arbitrated DIV>MUL>ALU with ALU anti-starvation into a registered writeback slot; define WB_ARB_BYPASS_EN to let an input entering an empty queue compete in its arrival cycle
module wb_result_arbiter #(
  parameter int DATA_W       = 64,
  parameter int PC_W         = 40,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              kill_i,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [4:0]        alu_rd_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [PC_W-1:0]   alu_pc_i,
  input  logic              mul_valid_i,
  output logic              mul_ready_o,
  input  logic [4:0]        mul_rd_i,
  input  logic [DATA_W-1:0] mul_result_i,
  input  logic [PC_W-1:0]   mul_pc_i,
  input  logic              div_valid_i,
  output logic              div_ready_o,
  input  logic [4:0]        div_rd_i,
  input  logic [DATA_W-1:0] div_result_i,
  input  logic [PC_W-1:0]   div_pc_i,
  output logic              wb_valid_o,
  output logic              wb_we_o,
  output logic [4:0]        wb_rd_o,
  output logic [DATA_W-1:0] wb_result_o,
  output logic [PC_W-1:0]   wb_pc_o,
  output logic [1:0]        wb_src_o
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int EW = 5 + DATA_W + PC_W;
  logic [EW-1:0] mem [3][FIFO_DEPTH];
  logic [AW-1:0] wptr [3];
  logic [AW-1:0] rptr [3];
  logic [CW-1:0] cnt [3];
  logic [EW-1:0] din [3];
  logic [EW-1:0] head [3];
  logic [2:0] vld, rdy, push, has, grant;
  logic [SW-1:0] starve;
  logic [1:0] src;
  logic [EW-1:0] win;
  logic promote;
  assign din[0] = {alu_rd_i, alu_result_i, alu_pc_i};
  assign din[1] = {mul_rd_i, mul_result_i, mul_pc_i};
  assign din[2] = {div_rd_i, div_result_i, div_pc_i};
  assign vld = {div_valid_i, mul_valid_i, alu_valid_i};
  assign {div_ready_o, mul_ready_o, alu_ready_o} = rdy;
  assign wb_we_o = wb_valid_o & (wb_rd_o != 5'd0);
  always_comb begin
    for (int s = 0; s < 3; s++) begin
      rdy[s]  = cnt[s] != CW'(FIFO_DEPTH);
      push[s] = vld[s] & rdy[s] & ~kill_i;
`ifdef WB_ARB_BYPASS_EN
      has[s]  = (cnt[s] != '0) | push[s];
`else
      has[s]  = cnt[s] != '0;
`endif
      head[s] = (cnt[s] != '0) ? mem[s][rptr[s]] : din[s];
    end
    promote = has[0] & (starve == SW'(STARVE_LIMIT));
    grant   = promote ? 3'b001 : has[2] ? 3'b100 : has[1] ? 3'b010 : {2'b00, has[0]};
    src     = grant[2] ? 2'd2 : grant[1] ? 2'd1 : 2'd0;
    win     = head[src];
  end
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < 3; s++)
      if (push[s]) mem[s][wptr[s]] <= din[s];
  end
  // a bypassed entry is written and popped in the same edge, leaving occupancy unchanged
  always_ff @(posedge clk_i) begin
    if (rst_i || kill_i) begin
      for (int s = 0; s < 3; s++) begin
        wptr[s] <= '0;
        rptr[s] <= '0;
        cnt[s]  <= '0;
      end
      starve      <= '0;
      wb_valid_o  <= 1'b0;
      wb_src_o    <= '0;
      wb_rd_o     <= '0;
      wb_result_o <= '0;
      wb_pc_o     <= '0;
    end else begin
      for (int s = 0; s < 3; s++) begin
        wptr[s] <= wptr[s] + AW'(push[s]);
        rptr[s] <= rptr[s] + AW'(grant[s]);
        cnt[s]  <= cnt[s] + CW'(push[s]) - CW'(grant[s]);
      end
      starve     <= (!has[0] || grant[0]) ? '0 : (starve == SW'(STARVE_LIMIT)) ? starve : starve + SW'(1);
      wb_valid_o <= |has;
      if (|has) begin
        wb_src_o                        <= src;
        {wb_rd_o, wb_result_o, wb_pc_o} <= win;
      end
    end
  end
endmodule

// File: tb/tb_wb_result_arbiter.sv
// tb_wb_result_arbiter: directed stimulus with a scoreboard queue drained by a writeback monitor
module tb_wb_result_arbiter;
  localparam int DW = 64;
  localparam int PW = 40;
`ifdef WB_ARB_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif
  typedef struct packed {
    logic [1:0]    src;
    logic [4:0]    rd;
    logic [DW-1:0] res;
    logic [PW-1:0] pc;
    logic          we;
  } ent_t;
  typedef struct packed {
    int   cyc;
    ent_t e;
  } stim_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic kill = 1'b0;
  logic [2:0] v = '0;
  logic [4:0] rd [3];
  logic [DW-1:0] res [3];
  logic [PW-1:0] pc [3];
  logic [2:0] rdy;
  logic wb_valid, wb_we;
  logic [4:0] wb_rd;
  logic [DW-1:0] wb_res;
  logic [PW-1:0] wb_pc;
  logic [1:0] wb_src;
  ent_t exp_q [$];
  stim_t stim_q [$];
  int out_cyc [$];
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  logic mrdy [64];

  wb_result_arbiter #(.DATA_W(DW), .PC_W(PW), .FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk_i(clk), .rst_i(rst), .kill_i(kill),
    .alu_valid_i(v[0]), .alu_ready_o(rdy[0]), .alu_rd_i(rd[0]), .alu_result_i(res[0]), .alu_pc_i(pc[0]),
    .mul_valid_i(v[1]), .mul_ready_o(rdy[1]), .mul_rd_i(rd[1]), .mul_result_i(res[1]), .mul_pc_i(pc[1]),
    .div_valid_i(v[2]), .div_ready_o(rdy[2]), .div_rd_i(rd[2]), .div_result_i(res[2]), .div_pc_i(pc[2]),
    .wb_valid_o(wb_valid), .wb_we_o(wb_we), .wb_rd_o(wb_rd), .wb_result_o(wb_res),
    .wb_pc_o(wb_pc), .wb_src_o(wb_src)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ent_t got, e;
    if (!rst && wb_valid) begin
      got.src = wb_src;
      got.rd  = wb_rd;
      got.res = wb_res;
      got.pc  = wb_pc;
      got.we  = wb_we;
      out_cyc.push_back(cyc);
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL wb_unexpected: got %h, scoreboard empty", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_bad++;
          $display("FAIL wb_entry: got %h expected %h", got, e);
        end
      end
    end
  end

  function automatic ent_t mk(input logic [1:0] s, input logic [4:0] r, input logic [DW-1:0] d, input logic [PW-1:0] p);
    mk.src = s;
    mk.rd  = r;
    mk.res = d;
    mk.pc  = p;
    mk.we  = (r != 5'd0);
  endfunction

  function automatic ent_t mkd(input logic [1:0] s, input logic [4:0] r);
    return mk(s, r, 64'hCAFE_0000_0000_0000 + 64'(s) * 64'd256 + 64'(r), 40'h80_0000_0000 + 40'(r) * 40'd4);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int c, input ent_t e);
    stim_t t;
    t.cyc = c;
    t.e   = e;
    stim_q.push_back(t);
  endtask

  // each source presents its oldest pending item once eligible and holds it until accepted
  task automatic run(input string name);
    int c;
    int idx [3];
    logic [2:0] acc;
    c = 0;
    while (stim_q.size() > 0 && c < 60) begin
      idx = '{-1, -1, -1};
      for (int i = 0; i < stim_q.size(); i++) begin
        int s;
        s = int'(stim_q[i].e.src);
        if (idx[s] == -1) idx[s] = (stim_q[i].cyc <= c) ? i : -2;
      end
      for (int s = 0; s < 3; s++) begin
        v[s] = idx[s] >= 0;
        if (idx[s] >= 0) begin
          rd[s]  = stim_q[idx[s]].e.rd;
          res[s] = stim_q[idx[s]].e.res;
          pc[s]  = stim_q[idx[s]].e.pc;
        end
      end
      @(negedge clk);
      acc = v & rdy;
      mrdy[c] = rdy[1];
      @(posedge clk);
      #1;
      v = '0;
      for (int i = stim_q.size() - 1; i >= 0; i--)
        for (int s = 0; s < 3; s++)
          if (acc[s] && idx[s] == i) stim_q.delete(i);
      c++;
    end
    check({"stim_", name}, 64'(stim_q.size()), 64'd0);
    stim_q.delete();
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({"drain_", name}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    for (int s = 0; s < 3; s++) begin
      rd[s]  = '0;
      res[s] = '0;
      pc[s]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", 64'(wb_valid), 64'd0);
    check("rst_we", 64'(wb_we), 64'd0);
    check("rst_rd", 64'(wb_rd), 64'd0);
    check("rst_result", wb_res, 64'd0);
    check("rst_pc", 64'(wb_pc), 64'd0);
    check("rst_src", 64'(wb_src), 64'd0);
    check("rst_ready", 64'(rdy), 64'd7);

    exp_q.push_back(mk(2'd0, 5'd5, 64'h1234, 40'h1000));
    v[0] = 1'b1; rd[0] = 5'd5; res[0] = 64'h1234; pc[0] = 40'h1000;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      v[0] = 1'b0;
      lat++;
    end while (!wb_valid && lat < 8);
    check("alu_latency", 64'(lat), 64'(EXP_LAT));
    check("alu_src", 64'(wb_src), 64'd0);
    check("alu_rd", 64'(wb_rd), 64'd5);
    drain("alu_alone");

    out_cyc.delete();
    add(0, mkd(2'd0, 5'd1)); add(0, mkd(2'd1, 5'd2)); add(0, mkd(2'd2, 5'd3));
    exp_q.push_back(mkd(2'd2, 5'd3)); exp_q.push_back(mkd(2'd1, 5'd2)); exp_q.push_back(mkd(2'd0, 5'd1));
    run("order");
    drain("order");
    check("order_count", 64'(out_cyc.size()), 64'd3);
    check("order_back2back", 64'(out_cyc[out_cyc.size()-1] - out_cyc[0]), 64'd2);

    add(0, mkd(2'd0, 5'd10));
    for (int k = 0; k < 6; k++) add(k, mkd(2'd2, 5'(20 + k)));
    for (int k = 0; k < 4; k++) exp_q.push_back(mkd(2'd2, 5'(20 + k)));
    exp_q.push_back(mkd(2'd0, 5'd10));
    exp_q.push_back(mkd(2'd2, 5'd24)); exp_q.push_back(mkd(2'd2, 5'd25));
    run("starve");
    drain("starve");

    for (int k = 0; k < 5; k++) add(k, mkd(2'd2, 5'(11 + k)));
    for (int k = 0; k < 3; k++) add(0, mkd(2'd1, 5'(16 + k)));
    for (int k = 0; k < 5; k++) exp_q.push_back(mkd(2'd2, 5'(11 + k)));
    for (int k = 0; k < 3; k++) exp_q.push_back(mkd(2'd1, 5'(16 + k)));
    run("mul_full");
    check("mul_ready_c0", 64'(mrdy[0]), 64'd1);
    check("mul_ready_c1", 64'(mrdy[1]), 64'd1);
    check("mul_ready_full", 64'(mrdy[2]), 64'd0);
    drain("mul_full");

    add(0, mk(2'd0, 5'd0, 64'hFF, 40'h2000));
    exp_q.push_back(mk(2'd0, 5'd0, 64'hFF, 40'h2000));
    run("rd0");
    drain("rd0");

    for (int k = 0; k < 2; k++) begin
      add(k, mkd(2'd0, 5'(4 + k))); add(k, mkd(2'd1, 5'(6 + k))); add(k, mkd(2'd2, 5'(8 + k)));
    end
    exp_q.push_back(mkd(2'd2, 5'd8));
`ifdef WB_ARB_BYPASS_EN
    exp_q.push_back(mkd(2'd2, 5'd9));
`endif
    run("fill");
    kill = 1'b1;
    v[2] = 1'b1; rd[2] = 5'd31; res[2] = 64'hDEAD; pc[2] = 40'hBAD;
    @(negedge clk);
    check("kill_full_ready", 64'(rdy[1:0]), 64'd0);
    @(posedge clk);
    #1;
    kill = 1'b0;
    v = '0;
    check("kill_valid", 64'(wb_valid), 64'd0);
    check("kill_ready", 64'(rdy), 64'd7);
    add(0, mkd(2'd0, 5'd12)); add(0, mkd(2'd1, 5'd13));
    exp_q.push_back(mkd(2'd1, 5'd13)); exp_q.push_back(mkd(2'd0, 5'd12));
    run("post_kill");
    drain("post_kill");

    v[0] = 1'b1; rd[0] = 5'd9; res[0] = 64'h99; pc[0] = 40'h90;
    v[1] = 1'b1; rd[1] = 5'd3; res[1] = 64'h33; pc[1] = 40'h30;
    @(posedge clk);
    #1;
    v = '0;
    v[2] = 1'b1; rd[2] = 5'd2; res[2] = 64'h22; pc[2] = 40'h20;
    rst = 1'b1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    kill = 1'b0;
    v = '0;
    check("midrst_valid", 64'(wb_valid), 64'd0);
    check("midrst_rd", 64'(wb_rd), 64'd0);
    check("midrst_ready", 64'(rdy), 64'd7);
    drain("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
